// File: rtl/mxs_pipe_sel_pkg.sv
// -----------------------------------------------------------------------------
// mxs_pkg
// Shared constants and helpers for the mxs_pipe_sel selector slice.
//   DEF_W / DEF_N : default channel data width and channel count
//   MODE_FIXED    : select the channel given by sel
//   MODE_RR       : round-robin among valid channels
//   wrap_add()    : (base + off) mod n for small non-negative operands
// -----------------------------------------------------------------------------
package mxs_pkg;

    localparam int DEF_W = 5;
    localparam int DEF_N = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Operands are always < n, so one conditional subtract replaces a true
    // modulo and stays cheap for non-power-of-two channel counts.
    function automatic int wrap_add(int base, int off, int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mxs_pipe_sel_if.sv
// -----------------------------------------------------------------------------
// mxs_pipe_sel_if
// Handshake bundle of the N:1 pipelined selector.
//   in_data   [N*W] : channel i at bits [i*W +: W]
//   in_valid  [N]   : per-channel valid
//   in_ready  [N]   : per-channel ready (driven by the selector)
//   mode            : MODE_FIXED / MODE_RR
//   sel       [SW]  : channel index for MODE_FIXED
//   out_data  [W]   : registered selected word
//   out_ch    [SW]  : registered index of the source channel
//   out_valid       : output register holds a word
//   out_ready       : downstream accepts the word
// Modports: master = upstream/downstream environment, slave = selector.
// -----------------------------------------------------------------------------
interface mxs_pipe_sel_if
    import mxs_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) ();

    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mxs_pipe_sel_rr_arb.sv
// -----------------------------------------------------------------------------
// mxs_rr_arb
// Combinational round-robin arbiter: first valid channel searching upward
// from rr_ptr_i, wrapping modulo N.
//   in_valid_i  [N]  : requests
//   rr_ptr_i    [SW] : highest-priority channel (always < N)
//   grant_o     [N]  : one-hot grant, zero when no request
//   grant_idx_o [SW] : encoded grant index (0 when no request)
// -----------------------------------------------------------------------------
module mxs_rr_arb
    import mxs_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  in_valid_i,
    input  logic [SW-1:0] rr_ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] grant_idx_o
);

    logic found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && in_valid_i[wrap_add(int'(rr_ptr_i), k, N)]) begin
                found                                      = 1'b1;
                grant_o[wrap_add(int'(rr_ptr_i), k, N)]    = 1'b1;
                grant_idx_o = SW'(wrap_add(int'(rr_ptr_i), k, N));
            end
        end
    end

endmodule

// File: rtl/mxs_pipe_sel.sv
// -----------------------------------------------------------------------------
// mxs_pipe_sel
// N:1 datapath selector with a registered output stage and valid/ready on
// every channel. Fixed-select or round-robin grant; one-cycle latency, one
// word per cycle when the downstream is ready.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mxs_pipe_sel_if.slave (channels in, selected word out)
// -----------------------------------------------------------------------------
module mxs_pipe_sel
    import mxs_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic          clk,
    input  logic          rst_n,
    mxs_pipe_sel_if.slave bus
);

    localparam int SW = $clog2(N);

    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_ch_q,    out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

    logic [N-1:0]  rr_grant;
    logic [SW-1:0] rr_idx;
    logic [N-1:0]  fix_grant;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [N-1:0]  in_ready;
    logic          can_load;
    logic          transfer;

    mxs_rr_arb #(.N(N)) u_arb (
        .in_valid_i  (bus.in_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (rr_grant),
        .grant_idx_o (rr_idx)
    );

    // Compare sel against every legal index rather than indexing with it, so
    // an out-of-range sel simply yields no grant.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SW'(i)) begin
                fix_grant[i] = bus.in_valid[i];
            end
        end
    end

    assign grant     = (bus.mode == MODE_RR) ? rr_grant : fix_grant;
    assign grant_idx = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;

    // out_ready reaches only in_ready; the output registers never see it
    // combinationally. Reset suppresses every grant.
    assign can_load = ~out_valid_q | bus.out_ready;
    assign in_ready = grant & {N{can_load & rst_n}};
    assign transfer = |(bus.in_valid & in_ready);

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_data_d  = bus.in_data[int'(grant_idx)*W +: W];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode == MODE_RR) begin
                rr_ptr_d = SW'(wrap_add(int'(grant_idx), 1, N));
            end
        end else if (out_valid_q && bus.out_ready) begin
            // Drained with nothing to replace it; data/channel keep stale values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge next-state value regardless of statement order.
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mxs_pipe_sel.sv
// -----------------------------------------------------------------------------
// tb_mxs_pipe_sel
// Directed, table-driven bench for mxs_pipe_sel (W=5, N=4). Inputs change on
// the falling edge; in_ready is checked 1 ns later, registered outputs 1 ns
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mxs_pipe_sel;

    localparam int W = 5;
    localparam int N = 4;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  in_valid;
        logic [19:0] in_data;
        logic        out_ready;
        logic [3:0]  exp_in_ready;
        logic        exp_valid;
        logic [4:0]  exp_data;
        logic [1:0]  exp_ch;
        logic [1:0]  exp_rr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [13];

    mxs_pipe_sel_if #(.W(W), .N(N)) bus ();

    mxs_pipe_sel #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pk(logic [4:0] c3, logic [4:0] c2,
                                       logic [4:0] c1, logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [1:0] sel,
                         input logic [3:0] valid, input logic [19:0] data,
                         input logic out_ready);
        bus.mode      = mode;
        bus.sel       = sel;
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = out_ready;
    endtask

    task automatic check_out(input string tag, input logic valid,
                             input logic [4:0] data, input logic [1:0] ch,
                             input logic [1:0] rr);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(valid));
        check({tag, " out_data"},  32'(bus.out_data),  32'(data));
        check({tag, " out_ch"},    32'(bus.out_ch),    32'(ch));
        check({tag, " rr_ptr"},    32'(dut.rr_ptr_q),  32'(rr));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // mode sel valid data out_rdy | in_ready valid data ch rr
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, pk(5'h00, 5'h13, 5'h00, 5'h00), 1'b1, 4'b0100, 1'b1, 5'h13, 2'd2, 2'd0};
        vecs[1]  = '{1'b0, 2'd1, 4'b1101, pk(5'h00, 5'h13, 5'h00, 5'h00), 1'b1, 4'b0000, 1'b0, 5'h13, 2'd2, 2'd0};
        vecs[2]  = '{1'b0, 2'd1, 4'b1101, pk(5'h00, 5'h13, 5'h00, 5'h00), 1'b1, 4'b0000, 1'b0, 5'h13, 2'd2, 2'd0};
        vecs[3]  = '{1'b0, 2'd3, 4'b1101, pk(5'h1F, 5'h00, 5'h00, 5'h00), 1'b0, 4'b1000, 1'b1, 5'h1F, 2'd3, 2'd0};
        vecs[4]  = '{1'b0, 2'd3, 4'b1101, pk(5'h1F, 5'h00, 5'h00, 5'h00), 1'b0, 4'b0000, 1'b1, 5'h1F, 2'd3, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1),     1'b1, 4'b0001, 1'b1, 5'd1,  2'd0, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1),     1'b1, 4'b0010, 1'b1, 5'd2,  2'd1, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1),     1'b1, 4'b0100, 1'b1, 5'd3,  2'd2, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1),     1'b1, 4'b1000, 1'b1, 5'd4,  2'd3, 2'd0};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1),     1'b1, 4'b0001, 1'b1, 5'd1,  2'd0, 2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b0001, pk(5'h00, 5'h00, 5'h00, 5'h07), 1'b1, 4'b0001, 1'b1, 5'h07, 2'd0, 2'd1};
        vecs[11] = '{1'b1, 2'd0, 4'b0000, pk(5'h00, 5'h00, 5'h00, 5'h07), 1'b1, 4'b0000, 1'b0, 5'h07, 2'd0, 2'd1};
        vecs[12] = '{1'b0, 2'd0, 4'b0001, pk(5'h00, 5'h00, 5'h00, 5'h0A), 1'b0, 4'b0001, 1'b1, 5'h0A, 2'd0, 2'd1};

        // Reset for two edges with every channel requesting.
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'h0);
        check_out("reset", 1'b0, 5'h00, 2'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed select, invalid select, round-robin fairness, skip idle, empty.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].mode, vecs[i].sel, vecs[i].in_valid, vecs[i].in_data,
                  vecs[i].out_ready);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(bus.in_ready),
                  32'(vecs[i].exp_in_ready));
            @(posedge clk);
            #1;
            check_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_ch, vecs[i].exp_rr);
            @(negedge clk);
        end

        // Backpressure: 5'h0A held for three stalled cycles, then drain+load.
        drive(1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1), 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
            check_out($sformatf("stall%0d", c), 1'b1, 5'h0A, 2'd0, 2'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(bus.in_ready), 32'b0010);
        @(posedge clk);
        #1;
        check_out("release", 1'b1, 5'd2, 2'd1, 2'd2);

        // Reset during a stall discards the held word and the pointer.
        @(negedge clk);
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst_stall in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        check_out("rst_stall", 1'b0, 5'h00, 2'd0, 2'd0);

        // First grant after reset starts from channel 0 again.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, pk(5'd4, 5'd3, 5'd2, 5'd1), 1'b1);
        #1;
        check("post_rst in_ready", 32'(bus.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check_out("post_rst", 1'b1, 5'd1, 2'd0, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
